hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Hazard and sequencing controller for the five-stage pipeline.
- Drives per-stage stall and flush enables for the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and the forwarding selects for the EX ALU operands.
- Sequences multi-cycle data-memory accesses in M with a wait-state FSM and a timeout.
- Keeps a saturating stall-cycle performance counter.

Parameters:
- MEM_TIMEOUT, 15: maximum number of wait cycles for one memory access before it is abandoned; range 1..255.
- CNT_W, 16: width of the stall performance counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RSTn  in  1  asynchronous, active-low reset.
- rsD, rtD  in  5 each  source registers of the instruction in D.
- rsE, rtE  in  5 each  source registers of the instruction in E.
- rtdE, rtdM, rtdW  in  5 each  destination registers in E, M and W.
- MtoRFSelE, MtoRFSelM  in  1 each  load indicator in E and in M.
- RFWEM, RFWEW  in  1 each  register-file write enable in M and in W.
- DMWEM  in  1  store in M.
- BranchM, ZeroM, JumpM  in  1 each  control-transfer resolution in M.
- DMRdyM  in  1  data memory has completed the access this cycle.
- ClrCnt  in  1  synchronous clear of the stall counter.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC / IF-ID / ID-EX / EX-MEM register.
- FlushD, FlushE, FlushM, FlushW  out  1 each  load a bubble (all control bits 0) into IF-ID / ID-EX / EX-MEM / MEM-WB.
- FwdAE, FwdBE  out  2 each  operand A / B select: 00 = register file, 01 = W result, 10 = ALUOutM.
- DMReqM  out  1  memory access request.
- MemErr  out  1  sticky: an access timed out.
- StallCnt  out  CNT_W  number of cycles in which StallF was asserted.

Behaviour:
- Reset (RSTn=0, asynchronous):
  - Registered state: state=RUN, wait counter=0, MemErr=0, StallCnt=0.
  - Outputs forced while RSTn=0: all Stall*=0, all Flush*=1, FwdAE=FwdBE=00, DMReqM=0.
- memop = MtoRFSelM | DMWEM. DMReqM = memop, combinational.
- Forwarding (combinational, M has priority over W):
  - FwdAE=10 if RFWEM && rtdM!=0 && rtdM==rsE.
  - Otherwise FwdAE=01 if RFWEW && rtdW!=0 && rtdW==rsE.
  - Otherwise FwdAE=00.
  - FwdBE uses the same rules with rtE in place of rsE.
- Load-use hazard: lu = MtoRFSelE && rtdE!=0 && (rtdE==rsD || rtdE==rtD). Response: StallF=StallD=1, FlushE=1.
- Memory FSM, states RUN and MEMWAIT; wcnt is 8 bits.
  - RUN:
    - memop && !DMRdyM: move to MEMWAIT, wcnt<=1.
    - Otherwise: remain in RUN.
  - MEMWAIT:
    - DMRdyM=1: move to RUN, wcnt<=0.
    - DMRdyM=0 and wcnt<MEM_TIMEOUT: wcnt<=wcnt+1.
    - DMRdyM=0 and wcnt==MEM_TIMEOUT (timeout cycle): move to RUN, MemErr<=1, wcnt<=0.
  - A memop entering M in RUN with DMRdyM=1 completes in zero wait cycles; no stall.
- Memory stall: ms = memop && !DMRdyM && !timeout_cycle.
  - Response: StallF=StallD=StallE=StallM=1, FlushW=1.
  - FlushW=1 is also asserted in the timeout cycle, so the abandoned result is not written back.
  - In the timeout cycle all stalls deassert and the pipeline advances.
- Control transfer: tk = (BranchM && ZeroM) | JumpM, gated by !ms. Response: FlushD=FlushE=FlushM=1. PC redirect is outside this block.
- Priority, highest first: ms > tk > lu.
  - During ms, lu and tk responses are suppressed; they are re-evaluated once the stall releases.
  - When tk and lu occur together, tk wins: no StallF/StallD, and FlushD/FlushE are asserted by tk.
- StallCnt:
  - Increments on each edge at which StallF=1 and ClrCnt=0.
  - Saturates at all-ones.
  - ClrCnt=1 loads 0; ClrCnt takes precedence over increment.
- MemErr: cleared only by reset.

Test Plan:
1. Forwarding: rsE=rtE=5, rtdM=5, RFWEM=1, rtdW=5, RFWEW=1 -> FwdAE=FwdBE=10. Same with rtdM=0 -> 01. Same with RFWEW=0 -> 00.
2. Load-use: MtoRFSelE=1, rtdE=8, rtD=8 -> StallF=StallD=FlushE=1 for exactly 1 cycle. StallCnt advances by 1.
3. Memory wait: load in M, DMRdyM low for 3 cycles then high -> StallF/D/E/M=1 for 3 cycles, deassert in the ready cycle, state returns to RUN. StallCnt advances by 3.
4. Timeout (MEM_TIMEOUT=4): DMRdyM held 0 -> stalls for the first 4 cycles. In the timeout cycle stalls are 0 and FlushW=1; MemErr=1 from the next cycle and stays 1.
5. Branch with load-use: BranchM=ZeroM=1 together with lu -> FlushD=FlushE=FlushM=1, StallF=StallD=0.
6. Reset: pull RSTn low in MEMWAIT mid-wait -> immediately state=RUN, Flush*=1, Stall*=0, MemErr=0, StallCnt=0. After release, a fresh load with DMRdyM=1 completes without stall.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: forwarding selects, load-use and control-transfer
// handling, memory wait-state sequencing with timeout, and a stall counter.
module hazard_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 16
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic [4:0]       rsD,
  input  logic [4:0]       rtD,
  input  logic [4:0]       rsE,
  input  logic [4:0]       rtE,
  input  logic [4:0]       rtdE,
  input  logic [4:0]       rtdM,
  input  logic [4:0]       rtdW,
  input  logic             MtoRFSelE,
  input  logic             MtoRFSelM,
  input  logic             RFWEM,
  input  logic             RFWEW,
  input  logic             DMWEM,
  input  logic             BranchM,
  input  logic             ZeroM,
  input  logic             JumpM,
  input  logic             DMRdyM,
  input  logic             ClrCnt,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushM,
  output logic             FlushW,
  output logic [1:0]       FwdAE,
  output logic [1:0]       FwdBE,
  output logic             DMReqM,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCnt
);

  typedef enum logic {RUN, MEMWAIT} state_t;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  state_t     state, state_next;
  logic [7:0] wcnt, wcnt_next;
  logic       err_set;
  logic       mem_err;
  logic       memop, timeout_cycle, ms, tk, lu, lu_raw;

  function automatic logic [1:0] fwd_sel(input logic [4:0] src);
    if (RFWEM && rtdM != 5'd0 && rtdM == src)
      return 2'b10;
    else if (RFWEW && rtdW != 5'd0 && rtdW == src)
      return 2'b01;
    else
      return 2'b00;
  endfunction

  // Hazard conditions, already resolved by priority ms > tk > lu
  always_comb begin
    memop         = MtoRFSelM | DMWEM;
    timeout_cycle = (state == MEMWAIT) && !DMRdyM && (wcnt == TIMEOUT);
    ms            = memop && !DMRdyM && !timeout_cycle;
    tk            = ((BranchM && ZeroM) || JumpM) && !ms;
    lu_raw        = MtoRFSelE && (rtdE != 5'd0) && ((rtdE == rsD) || (rtdE == rtD));
    lu            = lu_raw && !ms && !tk;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state   <= RUN;
      wcnt    <= 8'd0;
      mem_err <= 1'b0;
    end else begin
      state <= state_next;
      wcnt  <= wcnt_next;
      if (err_set)
        mem_err <= 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    wcnt_next  = wcnt;
    err_set    = 1'b0;
    case (state)
      RUN: begin
        if (memop && !DMRdyM) begin
          state_next = MEMWAIT;
          wcnt_next  = 8'd1;
        end
      end
      MEMWAIT: begin
        if (DMRdyM) begin
          state_next = RUN;
          wcnt_next  = 8'd0;
        end else if (wcnt < TIMEOUT) begin
          wcnt_next = wcnt + 8'd1;
        end else begin
          state_next = RUN;
          wcnt_next  = 8'd0;
          err_set    = 1'b1;
        end
      end
      default: begin
        state_next = RUN;
        wcnt_next  = 8'd0;
      end
    endcase
  end

  // While reset is held the pipeline registers all load bubbles
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b1;
    FlushE = 1'b1;
    FlushM = 1'b1;
    FlushW = 1'b1;
    FwdAE  = 2'b00;
    FwdBE  = 2'b00;
    DMReqM = 1'b0;
    if (RSTn) begin
      StallF = ms | lu;
      StallD = ms | lu;
      StallE = ms;
      StallM = ms;
      FlushD = tk;
      FlushE = tk | lu;
      FlushM = tk;
      FlushW = ms | timeout_cycle;
      FwdAE  = fwd_sel(rsE);
      FwdBE  = fwd_sel(rtE);
      DMReqM = memop;
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn)
      StallCnt <= '0;
    else if (ClrCnt)
      StallCnt <= '0;
    else if (StallF && StallCnt != {CNT_W{1'b1}})
      StallCnt <= StallCnt + 1'b1;
  end

  assign MemErr = mem_err;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios followed by random
// traffic compared against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int T  = 4;
  localparam int CW = 4;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic [4:0]    rsD, rtD, rsE, rtE, rtdE, rtdM, rtdW;
  logic          MtoRFSelE, MtoRFSelM, RFWEM, RFWEW, DMWEM;
  logic          BranchM, ZeroM, JumpM, DMRdyM, ClrCnt;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushM, FlushW;
  logic [1:0]    FwdAE, FwdBE;
  logic          DMReqM, MemErr;
  logic [CW-1:0] StallCnt;

  int n_assert = 0;
  int n_fail   = 0;

  // Model state: consecutive stalled cycles of the current access, error flag, count
  int m_pending;
  bit m_err;
  int m_cnt;

  hazard_ctrl #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .rtdE(rtdE), .rtdM(rtdM), .rtdW(rtdW),
    .MtoRFSelE(MtoRFSelE), .MtoRFSelM(MtoRFSelM),
    .RFWEM(RFWEM), .RFWEW(RFWEW), .DMWEM(DMWEM),
    .BranchM(BranchM), .ZeroM(ZeroM), .JumpM(JumpM),
    .DMRdyM(DMRdyM), .ClrCnt(ClrCnt),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
    .FwdAE(FwdAE), .FwdBE(FwdBE), .DMReqM(DMReqM),
    .MemErr(MemErr), .StallCnt(StallCnt)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_of(input logic [4:0] src);
    if (RFWEM && rtdM != 5'd0 && rtdM == src) return 2'b10;
    if (RFWEW && rtdW != 5'd0 && rtdW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Returns {ms, timeout, tk, lu} after priority resolution
  function automatic logic [3:0] eval_conds();
    logic memop, tmo, ms, tk, lu;
    memop = MtoRFSelM | DMWEM;
    tmo   = (m_pending == T) && !DMRdyM;
    ms    = memop && !DMRdyM && !tmo;
    tk    = ((BranchM && ZeroM) || JumpM) && !ms;
    lu    = MtoRFSelE && rtdE != 5'd0 && (rtdE == rsD || rtdE == rtD) && !ms && !tk;
    return {ms, tmo, tk, lu};
  endfunction

  task automatic check_output(input string tag);
    logic [3:0] c, es, ef;
    logic [1:0] fa, fb;
    logic       req;
    c = eval_conds();
    if (!RSTn) begin
      es = 4'b0000; ef = 4'b1111; fa = 2'b00; fb = 2'b00; req = 1'b0;
    end else begin
      req = MtoRFSelM | DMWEM;
      fa  = fwd_of(rsE);
      fb  = fwd_of(rtE);
      es  = c[3] ? 4'b1111 : (c[0] ? 4'b1100 : 4'b0000);
      ef  = {c[1], c[1] | c[0], c[1], c[3] | c[2]};
    end
    chk({tag, "/stall"}, 16'({StallF, StallD, StallE, StallM}), 16'(es));
    chk({tag, "/flush"}, 16'({FlushD, FlushE, FlushM, FlushW}), 16'(ef));
    chk({tag, "/fwda"}, 16'(FwdAE), 16'(fa));
    chk({tag, "/fwdb"}, 16'(FwdBE), 16'(fb));
    chk({tag, "/req"}, 16'(DMReqM), 16'(req));
  endtask

  // One clock: check combinational outputs, advance the model, check registers
  task automatic step(input string tag);
    logic [3:0] c;
    bit         sf;
    #2;
    check_output(tag);
    c  = eval_conds();
    sf = RSTn && (c[3] || c[0]);
    @(posedge CLK);
    if (!RSTn) begin
      m_pending = 0; m_err = 0; m_cnt = 0;
    end else begin
      if (c[2]) m_err = 1;
      m_pending = c[3] ? m_pending + 1 : 0;
      if (ClrCnt) m_cnt = 0;
      else if (sf && m_cnt < (1 << CW) - 1) m_cnt++;
    end
    #1;
    chk({tag, "/cnt"}, 16'(StallCnt), 16'(m_cnt));
    chk({tag, "/err"}, 16'(MemErr), 16'(m_err));
    @(negedge CLK);
  endtask

  task automatic idle();
    rsD = 0; rtD = 0; rsE = 0; rtE = 0; rtdE = 0; rtdM = 0; rtdW = 0;
    MtoRFSelE = 0; MtoRFSelM = 0; RFWEM = 0; RFWEW = 0; DMWEM = 0;
    BranchM = 0; ZeroM = 0; JumpM = 0; DMRdyM = 0; ClrCnt = 0;
  endtask

  task automatic apply_stimulus();
    if (m_pending == 0) begin
      MtoRFSelM = ($urandom_range(0, 3) == 0);
      DMWEM     = ($urandom_range(0, 5) == 0);
    end
    rsD = 5'($urandom_range(0, 3)); rtD = 5'($urandom_range(0, 3));
    rsE = 5'($urandom_range(0, 3)); rtE = 5'($urandom_range(0, 3));
    rtdE = 5'($urandom_range(0, 3)); rtdM = 5'($urandom_range(0, 3));
    rtdW = 5'($urandom_range(0, 3));
    MtoRFSelE = ($urandom_range(0, 2) == 0);
    RFWEM = $urandom_range(0, 1) == 1; RFWEW = $urandom_range(0, 1) == 1;
    BranchM = ($urandom_range(0, 4) == 0); ZeroM = $urandom_range(0, 1) == 1;
    JumpM = ($urandom_range(0, 9) == 0);
    DMRdyM = ($urandom_range(0, 9) < 4);
    ClrCnt = ($urandom_range(0, 19) == 0);
  endtask

  initial begin
    m_pending = 0; m_err = 0; m_cnt = 0;
    idle();
    RSTn = 1'b0;
    @(negedge CLK);
    step("por");
    RSTn = 1'b1;
    step("idle");

    $display("[TB] forwarding");
    rsE = 5; rtE = 5; rtdM = 5; RFWEM = 1; rtdW = 5; RFWEW = 1;
    #1; chk("fwd_m_a", 16'(FwdAE), 16'd2); chk("fwd_m_b", 16'(FwdBE), 16'd2);
    step("fwd_m");
    rtdM = 0;
    #1; chk("fwd_w_a", 16'(FwdAE), 16'd1); chk("fwd_w_b", 16'(FwdBE), 16'd1);
    step("fwd_w");
    RFWEW = 0;
    #1; chk("fwd_rf_a", 16'(FwdAE), 16'd0);
    step("fwd_rf");
    idle();

    $display("[TB] load-use");
    MtoRFSelE = 1; rtdE = 8; rtD = 8;
    #1; chk("lu_resp", 16'({StallF, StallD, FlushE}), 16'b111);
    step("lu");
    idle();
    #1; chk("lu_release", 16'(StallF), 16'd0);
    chk("lu_cnt", 16'(StallCnt), 16'd1);
    step("lu_after");

    $display("[TB] memory wait");
    MtoRFSelM = 1; DMRdyM = 0;
    for (int i = 0; i < 3; i++) begin
      #1; chk("mw_stall", 16'({StallF, StallD, StallE, StallM}), 16'hF);
      step("mw");
    end
    DMRdyM = 1;
    #1; chk("mw_ready", 16'({StallF, StallD, StallE, StallM}), 16'h0);
    step("mw_rdy");
    chk("mw_cnt", 16'(StallCnt), 16'd4);
    idle(); MtoRFSelM = 1; DMRdyM = 1;
    #1; chk("mw_zero_wait", 16'(StallF), 16'd0);
    step("mw_zw");

    $display("[TB] timeout");
    DMRdyM = 0;
    for (int i = 0; i < T; i++) begin
      #1; chk("to_stall", 16'({StallF, StallM}), 16'h3);
      step("to");
    end
    #1; chk("to_cycle", 16'({StallF, StallD, StallE, StallM, FlushW}), 16'b00001);
    chk("to_err_pre", 16'(MemErr), 16'd0);
    step("to_fin");
    chk("to_err", 16'(MemErr), 16'd1);
    idle();
    step("to_idle0");
    step("to_idle1");
    chk("to_err_sticky", 16'(MemErr), 16'd1);

    $display("[TB] saturation and clear");
    MtoRFSelE = 1; rtdE = 3; rsD = 3;
    for (int i = 0; i < 10; i++) step("sat");
    chk("sat_cnt", 16'(StallCnt), 16'hF);
    ClrCnt = 1;
    step("clr");
    chk("clr_cnt", 16'(StallCnt), 16'd0);
    idle();

    $display("[TB] branch with load-use");
    MtoRFSelE = 1; rtdE = 8; rtD = 8; BranchM = 1; ZeroM = 1;
    #1; chk("br_flush", 16'({FlushD, FlushE, FlushM}), 16'b111);
    chk("br_nostall", 16'({StallF, StallD}), 16'b00);
    step("br");
    idle();

    $display("[TB] reset mid-wait");
    MtoRFSelM = 1; DMRdyM = 0;
    step("rw0");
    step("rw1");
    RSTn = 1'b0;
    m_pending = 0; m_err = 0; m_cnt = 0;
    #1;
    chk("rst_stall", 16'({StallF, StallD, StallE, StallM}), 16'h0);
    chk("rst_flush", 16'({FlushD, FlushE, FlushM, FlushW}), 16'hF);
    chk("rst_err", 16'(MemErr), 16'd0);
    chk("rst_cnt", 16'(StallCnt), 16'd0);
    step("rst_hold");
    RSTn = 1'b1; DMRdyM = 1;
    #1; chk("rst_fresh", 16'({StallF, StallM}), 16'h0);
    step("rst_fresh");

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      apply_stimulus();
      step("rnd");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
